// File: rtl/lsosc_pkg.sv
//------------------------------------------------------------------------------
// Module  : lsosc_pkg
// Purpose : Shared state encoding, default parameters and elaboration helpers
//           for the low-speed oscillator controller.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package lsosc_pkg;

  typedef enum logic [2:0] {
    ST_OFF   = 3'd0,
    ST_START = 3'd1,
    ST_RUN   = 3'd2,
    ST_STOP  = 3'd3,
    ST_FAULT = 3'd4
  } lsosc_state_e;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_READY_EDGES = 4;
  localparam int DEF_TIMEOUT_CYC = 4096;
  localparam int DEF_QUIET_CYC   = 2048;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lsosc_edge_sync.sv
//------------------------------------------------------------------------------
// Module  : lsosc_edge_sync
// Purpose : Multi-flop synchronizer for a slow asynchronous clock with a
//           registered one-cycle rising-edge pulse (latency SYNC_STAGES+1).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module lsosc_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_sig,
  output logic tick
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
      tick   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_sig};
      hist_q <= sync_q[SYNC_STAGES-1];
      tick   <= sync_q[SYNC_STAGES-1] & ~hist_q;
    end
  end

endmodule

`default_nettype wire

// File: rtl/lsosc_ctrl.sv
//------------------------------------------------------------------------------
// Module  : lsosc_ctrl
// Purpose : System-clock-side enable/qualify/supervise controller for the
//           LSOSC core. Optional LF period measurement: LSOSC_CTRL_PERIOD_MEAS_EN.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module lsosc_ctrl
  import lsosc_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int READY_EDGES = DEF_READY_EDGES,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int QUIET_CYC   = DEF_QUIET_CYC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        lf_clk_i,
  output logic        osc_ena_o,
  output logic        ready_o,
  output logic        lf_tick_o,
  output logic        busy_o,
  output logic        fault_o
`ifdef LSOSC_CTRL_PERIOD_MEAS_EN
  ,
  output logic [15:0] period_o,
  output logic        period_vld_o
`endif
);

  localparam int TW = max2(clog2(max2(TIMEOUT_CYC, QUIET_CYC)), 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0] QUIET_LAST   = TW'(QUIET_CYC - 1);
  localparam logic [7:0]    READY_LAST   = 8'(READY_EDGES - 1);

  lsosc_state_e  state, state_nxt;
  logic [TW-1:0] timer;
  logic [7:0]    edge_cnt;
  logic          tick;
  logic          timer_hit_to;
  logic          timer_hit_quiet;

  lsosc_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .async_sig (lf_clk_i),
    .tick      (tick)
  );

  assign lf_tick_o = tick;

  // An edge arriving in the expiry cycle still counts as proof of life.
  assign timer_hit_to    = !tick && (timer == TIMEOUT_LAST);
  assign timer_hit_quiet = !tick && (timer == QUIET_LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_OFF:   if (req) state_nxt = ST_START;
      ST_START: begin
        if (!req)                                  state_nxt = ST_STOP;
        else if (tick && (edge_cnt == READY_LAST)) state_nxt = ST_RUN;
        else if (timer_hit_to)                     state_nxt = ST_FAULT;
      end
      ST_RUN: begin
        if (!req)              state_nxt = ST_STOP;
        else if (timer_hit_to) state_nxt = ST_FAULT;
      end
      ST_STOP:  if (timer_hit_quiet) state_nxt = ST_OFF;
      ST_FAULT: if (!req) state_nxt = ST_OFF;
      default:  state_nxt = ST_OFF;
    endcase
  end

  // Outputs are decoded from the next state so they align with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_OFF;
      timer     <= '0;
      edge_cnt  <= 8'd0;
      osc_ena_o <= 1'b0;
      ready_o   <= 1'b0;
      busy_o    <= 1'b0;
      fault_o   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (tick || (state_nxt != state)) timer <= '0;
      else if (timer != {TW{1'b1}})     timer <= timer + TW'(1);
      if (state != ST_START) edge_cnt <= 8'd0;
      else if (tick)         edge_cnt <= edge_cnt + 8'd1;
      osc_ena_o <= (state_nxt == ST_START) || (state_nxt == ST_RUN);
      ready_o   <= (state_nxt == ST_RUN);
      busy_o    <= (state_nxt == ST_START) || (state_nxt == ST_STOP);
      fault_o   <= (state_nxt == ST_FAULT);
    end
  end

`ifdef LSOSC_CTRL_PERIOD_MEAS_EN
  logic [15:0] per_cnt;
  logic        per_armed;

  // Counter restarts at 1 so the value seen at the next tick equals the period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per_cnt      <= 16'd0;
      per_armed    <= 1'b0;
      period_o     <= 16'd0;
      period_vld_o <= 1'b0;
    end else begin
      period_vld_o <= 1'b0;
      if (tick)                   per_cnt <= 16'd1;
      else if (per_cnt != 16'hFFFF) per_cnt <= per_cnt + 16'd1;
      if (state != ST_RUN) begin
        per_armed <= 1'b0;
      end else if (tick) begin
        per_armed <= 1'b1;
        if (per_armed) begin
          period_o     <= per_cnt;
          period_vld_o <= 1'b1;
        end
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_lsosc_ctrl.sv
//------------------------------------------------------------------------------
// Module  : tb_lsosc_ctrl
// Purpose : Self-checking bench for lsosc_ctrl (vector table + directed sequences).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_lsosc_ctrl;

  localparam int READY = 4;

  logic clk = 1'b0;
  logic rst_n, req, lf_man, lf_auto, lf_gen, lf_clk;
  logic osc_ena, ready, tick, busy, fault;
`ifdef LSOSC_CTRL_PERIOD_MEAS_EN
  logic [15:0] period;
  logic        period_vld;
`endif

  int total = 0;
  int bad   = 0;

  assign lf_clk = lf_auto ? lf_gen : lf_man;

  always #5 clk = ~clk;

  lsosc_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .lf_clk_i  (lf_clk),
    .osc_ena_o (osc_ena),
    .ready_o   (ready),
    .lf_tick_o (tick),
    .busy_o    (busy),
    .fault_o   (fault)
`ifdef LSOSC_CTRL_PERIOD_MEAS_EN
    ,
    .period_o     (period),
    .period_vld_o (period_vld)
`endif
  );

  // LF oscillator model: 200 clk period, starts low when enabled.
  initial begin
    int gcnt;
    gcnt   = 0;
    lf_gen = 1'b0;
    forever begin
      @(negedge clk);
      if (lf_auto) begin
        if (gcnt == 99) begin
          gcnt   = 0;
          lf_gen = ~lf_gen;
        end else begin
          gcnt++;
        end
      end else begin
        gcnt   = 0;
        lf_gen = 1'b0;
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [4:0] outs();
    return {osc_ena, ready, tick, busy, fault};
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_ready(input string name);
    int   ticks, run, maxrun;
    logic prev;
    bit   done;
    ticks = 0; run = 0; maxrun = 0; prev = 1'b0; done = 0;
    for (int c = 0; c < 2000 && !done; c++) begin
      @(posedge clk); #1;
      if (ready) begin
        done = 1;
        check({name, " ticks_before_ready"}, 16'(ticks), 16'(READY));
        check({name, " tick_prev_cycle"}, 16'(prev), 16'd1);
        check({name, " osc_ena"}, 16'(osc_ena), 16'd1);
      end else begin
        if (tick) ticks++;
        run    = tick ? run + 1 : 0;
        maxrun = (run > maxrun) ? run : maxrun;
        prev   = tick;
      end
    end
    check({name, " ready_reached"}, 16'(done), 16'd1);
    check({name, " tick_width"}, 16'(maxrun), 16'd1);
  endtask

  task automatic wait_tick(input string name);
    bit found;
    found = 0;
    for (int c = 0; c < 400 && !found; c++) begin
      @(posedge clk); #1;
      if (tick) found = 1;
    end
    check({name, " tick_seen"}, 16'(found), 16'd1);
  endtask

`ifdef LSOSC_CTRL_PERIOD_MEAS_EN
  task automatic wait_vld(input string name);
    bit found;
    found = 0;
    for (int c = 0; c < 1000 && !found; c++) begin
      @(posedge clk); #1;
      if (period_vld) found = 1;
    end
    check({name, " vld_seen"}, 16'(found), 16'd1);
    check({name, " period"}, period, 16'd200);
  endtask
`endif

  typedef struct packed {
    logic       req;
    logic       lf;
    logic [4:0] exp;   // {osc_ena, ready, tick, busy, fault}
  } vec_t;

  vec_t vecs [22];

  initial begin
    vecs[0]  = '{1'b0, 1'b0, 5'b00000};
    vecs[1]  = '{1'b1, 1'b0, 5'b10010};
    vecs[2]  = '{1'b1, 1'b1, 5'b10010};
    vecs[3]  = '{1'b1, 1'b1, 5'b10010};
    vecs[4]  = '{1'b1, 1'b0, 5'b10110};
    vecs[5]  = '{1'b1, 1'b0, 5'b10010};
    vecs[6]  = '{1'b1, 1'b1, 5'b10010};
    vecs[7]  = '{1'b1, 1'b1, 5'b10010};
    vecs[8]  = '{1'b1, 1'b0, 5'b10110};
    vecs[9]  = '{1'b1, 1'b0, 5'b10010};
    vecs[10] = '{1'b1, 1'b1, 5'b10010};
    vecs[11] = '{1'b1, 1'b1, 5'b10010};
    vecs[12] = '{1'b1, 1'b0, 5'b10110};
    vecs[13] = '{1'b1, 1'b0, 5'b10010};
    vecs[14] = '{1'b1, 1'b1, 5'b10010};
    vecs[15] = '{1'b1, 1'b1, 5'b10010};
    vecs[16] = '{1'b1, 1'b0, 5'b10110};
    vecs[17] = '{1'b1, 1'b0, 5'b11000};
    vecs[18] = '{1'b0, 1'b0, 5'b00010};
    vecs[19] = '{1'b0, 1'b1, 5'b00010};
    vecs[20] = '{1'b0, 1'b1, 5'b00010};
    vecs[21] = '{1'b0, 1'b0, 5'b00110};

    rst_n = 1'b0; req = 1'b0; lf_man = 1'b0; lf_auto = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("in_reset", 16'(outs()), 16'd0);
    @(negedge clk) rst_n = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk); #1;
      check("idle_after_reset", 16'(outs()), 16'd0);
    end

    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      req    = vecs[i].req;
      lf_man = vecs[i].lf;
      @(posedge clk); #1;
      check($sformatf("vec%0d", i), 16'(outs()), 16'(vecs[i].exp));
    end

    // STOP quiet period: last tick just seen; OFF 2049 edges later.
    repeat (2048) @(posedge clk);
    #1 check("stop_quiet_pre", 16'(outs()), 16'b00010);
    @(posedge clk); #1;
    check("stop_quiet_off", 16'(outs()), 16'd0);

    // Normal start with modelled LF, then loss of clock in RUN.
    req = 1'b1; lf_man = 1'b0; lf_auto = 1'b1;
    wait_ready("start1");
`ifdef LSOSC_CTRL_PERIOD_MEAS_EN
    wait_vld("meas1");
    wait_vld("meas2");
`endif
    wait_tick("loss");
    lf_auto = 1'b0;
    repeat (4096) @(posedge clk);
    #1 check("loss_pre", 16'(outs()), 16'b11000);
    @(posedge clk); #1;
    check("loss_fault", 16'(outs()), 16'b00001);
`ifdef LSOSC_CTRL_PERIOD_MEAS_EN
    check("period_hold_fault", period, 16'd200);
`endif
    repeat (5) @(posedge clk);
    #1 check("fault_held_req1", 16'(outs()), 16'b00001);
    req = 1'b0;
    @(posedge clk); #1;
    check("fault_exit_off", 16'(outs()), 16'd0);

    // Start timeout with LF held low.
    req = 1'b1;
    @(posedge clk); #1;
    check("to_start", 16'(outs()), 16'b10010);
    repeat (4095) @(posedge clk);
    #1 check("to_pre", 16'(outs()), 16'b10010);
    @(posedge clk); #1;
    check("to_fault", 16'(outs()), 16'b00001);
    req = 1'b0;
    @(posedge clk); #1;
    check("to_exit_off", 16'(outs()), 16'd0);

    // Restart after fault, then req drop coinciding with timeout.
    req = 1'b1; lf_auto = 1'b1;
    wait_ready("restart");
    wait_tick("simul");
    lf_auto = 1'b0;
    repeat (4096) @(posedge clk);
    #1 req = 1'b0;
    @(posedge clk); #1;
    check("simul_stop", 16'(outs()), 16'b00010);
`ifdef LSOSC_CTRL_PERIOD_MEAS_EN
    check("period_hold_stop", period, 16'd200);
    check("period_vld_stop", 16'(period_vld), 16'd0);
`endif

    // req reasserted in STOP must not shortcut back to RUN.
    req = 1'b1;
    repeat (10) @(posedge clk);
    #1 check("stop_hold_req", 16'(outs()), 16'b00010);

    // Asynchronous reset mid-operation.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_reset", 16'(outs()), 16'd0);
`ifdef LSOSC_CTRL_PERIOD_MEAS_EN
    check("async_reset_period", period, 16'd0);
`endif
    req = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_reset_off", 16'(outs()), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/lsosc_ctrl.md
Name: lsosc_ctrl

Overview:
System-clock-side controller for the iCE40UP low-speed oscillator core (LSOSC_CORE_SUB).
- Requests the oscillator by driving its enable.
- Synchronizes the returned low-frequency clock into clk and issues one-cycle ticks per LF rising edge.
- Declares the clock ready after a programmable number of edges, and supervises stop, loss-of-clock and start timeout.
- Sits between power/sleep logic (req) and slow-timer consumers (lf_tick_o, ready_o).

Parameters:
- SYNC_STAGES, 2, synchronizer flops on lf_clk_i (legal 2..4).
- READY_EDGES, 4, LF rising edges seen in START before ready_o asserts (1..255).
- TIMEOUT_CYC, 4096, clk cycles allowed without an LF edge in START/RUN before FAULT (≥ 2 LF periods).
- QUIET_CYC, 2048, consecutive edge-free clk cycles in STOP that prove the oscillator has halted.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  asynchronous active-low reset; deassertion is synchronous to clk externally.
- req  in  1  level: 1 = oscillator wanted.
- lf_clk_i  in  1  LF clock from the oscillator core (asynchronous to clk).
- osc_ena_o  out  1  enable to the oscillator core; registered.
- ready_o  out  1  LF clock running and qualified.
- lf_tick_o  out  1  one-clk pulse per synchronized LF rising edge.
- busy_o  out  1  high in START or STOP.
- fault_o  out  1  high in FAULT.

Behaviour:
Reset
- All outputs are 0; state = OFF; synchronizer, edge and timer counters are 0.

Edge detect
- lf_clk_i passes through SYNC_STAGES flops plus one history flop.
- tick = sync & ~hist.
- lf_tick_o is valid in every state; latency is SYNC_STAGES+1 clk rising edges after the LF rise.

Timer
- One counter, width clog2(max(TIMEOUT_CYC, QUIET_CYC)).
- Clears on any tick and on every state change; otherwise increments and saturates.

Edge counter
- 8 bits; cleared on entry to START; increments on tick in START.

States
- OFF: osc_ena_o=0. If req=1, go to START on the next cycle.
- START: osc_ena_o=1, busy_o=1.
  - Edge count reaching READY_EDGES (on a tick) → RUN; ready_o=1 from the following cycle.
  - Timer reaching TIMEOUT_CYC-1 → FAULT.
  - req=0 → STOP; req=0 has priority over both ready and timeout in the same cycle.
- RUN: osc_ena_o=1, ready_o=1.
  - req=0 → STOP.
  - Timer reaching TIMEOUT_CYC-1 (loss of clock) → FAULT; req=0 wins if simultaneous.
- STOP: osc_ena_o=0, ready_o=0, busy_o=1.
  - The core may emit further edges after disable; each tick restarts the timer.
  - Timer reaching QUIET_CYC-1 → OFF.
  - req reasserted in STOP is held: the sequence is STOP → OFF → START, with no shortcut back to RUN.
- FAULT: osc_ena_o=0, fault_o=1.
  - Exits to OFF only when req=0 (the requester must retract), then restarts via OFF.

General rules
- ready_o is never 1 while osc_ena_o is 0.
- osc_ena_o changes only on state transitions.
- Reset mid-operation returns to OFF immediately.

Optional Feature:
LSOSC_CTRL_PERIOD_MEAS_EN
- Defined: adds output period_o [15:0] and period_vld_o.
  - A 16-bit counter counts clk cycles between consecutive ticks; it saturates at 16'hFFFF.
  - In RUN, each tick loads the count into period_o and pulses period_vld_o for one cycle.
  - The first tick after entering RUN only restarts the counter.
  - period_o resets to 0 and holds its value outside RUN.
- Undefined: the ports are absent and no counter is built.

Decomposition:
- Package lsosc_pkg: state enum (OFF, START, RUN, STOP, FAULT; 3-bit), default parameter constants, and a clog2 helper.
- One sub-module: lsosc_edge_sync (synchronizer + rising-edge detector, parameter SYNC_STAGES). It is reusable for other slow asynchronous clocks.

Test Plan:
- Reset release with req=0 and LF idle → all outputs 0 for 100 cycles; state OFF.
- req=1, LF model period 200 clk cycles, READY_EDGES=4 → osc_ena_o=1 next cycle; ready_o=1 exactly 1 cycle after the 4th tick; lf_tick_o is 1-cycle wide at SYNC_STAGES+1 latency.
- In RUN, drop req; model emits 2 extra edges after disable → ready_o=0 and osc_ena_o=0 next cycle; OFF reached QUIET_CYC cycles after the last tick.
- req=1 with LF held low, TIMEOUT_CYC=4096 → fault_o=1 at cycle 4096 after entering START and osc_ena_o=0; req=0 → OFF; req=1 → restart succeeds.
- In RUN, stop LF for 5000 cycles → FAULT; in a separate run, req=0 in the same cycle as the timeout → STOP, not FAULT.
- LSOSC_CTRL_PERIOD_MEAS_EN with LF period 200 clk → period_o=200 on each period_vld_o after the first RUN tick; the value holds after req=0.
